corelet_ctrl: RTL and testbench
===============================

CORELET_CTRL -- requirements
Module: corelet_ctrl

Interface
REQ-001 SHALL have parameters: row 8 (PE rows / L0 lanes); col 8 (PE columns); len_kij 9 (kernel positions); len_nij 36 (activation vectors per pass); aw 11 (SRAM address width); kbase 0 (kernel base address in xmem); abase 0x400 (activation base address in xmem).
REQ-002 SHALL have ports (name / direction / width / meaning):
- clk / in / 1 / clock
- reset / in / 1 / async active-low reset
- start / in / 1 / one-cycle pulse; begins a full convolution
- busy / out / 1 / high outside IDLE
- done / out / 1 / one-cycle pulse at completion
- l0_o_full / in / 1 / L0 full
- l0_o_ready / in / 1 / L0 not full
- ofifo_o_valid / in / 1 / OFIFO holds a complete row
- xmem_cen / out / 1 / xmem chip enable, active-low
- xmem_addr / out / aw / xmem read address
- l0_wr / out / 1 / L0 write strobe
- l0_rd / out / 1 / L0 read strobe
- load / out / 1 / drives inst[0]
- execute / out / 1 / drives inst[1]
- ofifo_rd / out / 1 / OFIFO read strobe
- pmem_wen / out / 1 / psum SRAM write enable, active-low
- pmem_addr / out / aw / psum SRAM write address
- kij / out / 4 / current kernel index

Function
REQ-003 SHALL implement states IDLE, KL0, KPE, KFLUSH, AL0, EXEC, DRAIN, NEXT, DONE; all state and outputs SHALL be registered.
REQ-004 IDLE -> KL0 on start; start SHALL be ignored in all other states.
REQ-005 KL0: issue col xmem reads at xmem_addr = kbase + kij*col + i (i = 0..col-1).
REQ-006 A read SHALL be issued only in a cycle with l0_o_full = 0; otherwise xmem_cen = 1 and the address is held.
REQ-007 l0_wr SHALL assert exactly one cycle after each issued read (1-cycle SRAM latency).
REQ-008 KL0 -> KPE once the last l0_wr has been emitted.
REQ-009 KPE: assert l0_rd = 1 and load = 1 for exactly col consecutive cycles, then go to KFLUSH.
REQ-010 KFLUSH: all strobes low for row + col cycles (kernel propagation), then go to AL0.
REQ-011 AL0: same protocol as KL0 (REQ-006/007), with len_nij reads at abase + n.
REQ-012 AL0 -> EXEC after the last l0_wr.
REQ-013 EXEC: assert l0_rd = 1 and execute = 1 for exactly len_nij cycles, then go to DRAIN.
REQ-014 DRAIN: ofifo_rd = ofifo_o_valid each cycle.
REQ-015 pmem_wen SHALL be 0 exactly one cycle after each ofifo_rd, with pmem_addr = kij*len_nij + m, where m is the drained-row count starting at 0.
REQ-016 DRAIN -> NEXT after the len_nij-th write.
REQ-017 NEXT: if kij == len_kij-1, go to DONE; otherwise increment kij and go to KL0.
REQ-018 DONE: pulse done for one cycle, clear kij to 0, return to IDLE.
REQ-019 load and execute SHALL never be high in the same cycle; l0_wr and l0_rd SHALL never be high in the same cycle.
REQ-020 Address arithmetic SHALL be modulo 2^aw; an overflow SHALL wrap and SHALL NOT be flagged.
REQ-021 Total written rows per run SHALL equal len_kij*len_nij (324 with defaults).

Reset
REQ-022 While reset = 0, asynchronously force: state IDLE; kij 0; all counters 0; xmem_cen 1; pmem_wen 1; l0_wr, l0_rd, load, execute, ofifo_rd, busy, done all 0; addresses 0.
REQ-023 Reset asserted mid-run SHALL abort the run without emitting done.
REQ-024 After reset deasserts, the block SHALL wait in IDLE for a fresh start.

Verification
REQ-025 Default parameters, L0/OFIFO models never stall, single start -> 9 passes; exactly 324 pmem writes at addresses 0..323 in order; a single done pulse; busy low afterwards.
REQ-026 Pass 0, KL0 -> xmem_addr 0..7, and l0_wr trails each read by one cycle.
REQ-027 Pass 0, KPE -> load high for exactly 8 consecutive cycles, then exactly 16 idle cycles, then the first AL0 read at address 0x400.
REQ-028 Hold l0_o_full = 1 for 5 cycles during AL0 -> xmem_cen = 1 and the address is held; after release the read sequence continues with no skipped or duplicate addresses; still 36 l0_wr in total.
REQ-029 Toggle ofifo_o_valid randomly during DRAIN -> ofifo_rd only while valid; pmem_addr contiguous; the DRAIN exit happens after exactly 36 writes.
REQ-030 Assert reset low during pass 3 EXEC -> all outputs at REQ-022 values in the same cycle; no done pulse; a subsequent start restarts from kij = 0.

Source files
------------

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequencer for one full convolution over a weight-stationary
// PE array. For each kernel position kij it loads a kernel slice into L0,
// pushes it into the PEs, streams the activation vectors through, and drains
// the resulting partial-sum rows from the OFIFO into psum SRAM.
//
// Handshakes seen by this block:
//   - xmem read: xmem_cen low for one cycle with xmem_addr valid; data lands
//     one cycle later, so l0_wr is the read enable delayed by one cycle.
//   - L0 push: a read is only launched when L0 reported space (l0_o_full low,
//     l0_o_ready high) on the clock edge that launches it.
//   - OFIFO pop: ofifo_rd is raised for rows that OFIFO reported valid on the
//     launching edge; pmem_wen follows ofifo_rd by one cycle.
// All outputs come straight from flops.
module corelet_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_kij = 9,
    parameter int len_nij = 36,
    parameter int aw      = 11,
    parameter int kbase   = 0,
    parameter int abase   = 'h400
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          l0_o_full,
    input  logic          l0_o_ready,
    input  logic          ofifo_o_valid,
    output logic          xmem_cen,
    output logic [aw-1:0] xmem_addr,
    output logic          l0_wr,
    output logic          l0_rd,
    output logic          load,
    output logic          execute,
    output logic          ofifo_rd,
    output logic          pmem_wen,
    output logic [aw-1:0] pmem_addr,
    output logic [3:0]    kij
);

    // One counter width covers every phase length this block has to count.
    localparam int cmax_a = (len_nij > col) ? len_nij : col;
    localparam int cmax   = (cmax_a > (row + col)) ? cmax_a : (row + col);
    localparam int cw     = $clog2(cmax + 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_KL0    = 4'd1,
        S_KPE    = 4'd2,
        S_KFLUSH = 4'd3,
        S_AL0    = 4'd4,
        S_EXEC   = 4'd5,
        S_DRAIN  = 4'd6,
        S_NEXT   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      kij_q, kij_d;
    logic [cw-1:0]   cnt_q, cnt_d;      // phase length counter (KPE/KFLUSH/EXEC)
    logic [cw-1:0]   issue_q, issue_d;  // xmem reads launched in this fill
    logic [cw-1:0]   l0w_q, l0w_d;      // l0_wr strobes emitted in this fill
    logic [cw-1:0]   ordc_q, ordc_d;    // OFIFO rows popped in this drain
    logic [cw-1:0]   pwc_q, pwc_d;      // psum rows written in this drain

    logic            xmem_cen_q, xmem_cen_d;
    logic [aw-1:0]   xmem_addr_q, xmem_addr_d;
    logic            l0_wr_q, l0_wr_d;
    logic            l0_rd_q, l0_rd_d;
    logic            load_q, load_d;
    logic            execute_q, execute_d;
    logic            ofifo_rd_q, ofifo_rd_d;
    logic            pmem_wen_q, pmem_wen_d;
    logic [aw-1:0]   pmem_addr_q, pmem_addr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            l0_space;
    logic [cw-1:0]   fill_len;

    // Kernel slice address: kbase + k*col + i, wrapping modulo 2^aw.
    function automatic logic [aw-1:0] k_addr(input logic [3:0] k, input logic [cw-1:0] i);
        logic [31:0] a;
        a = 32'(kbase) + 32'(k) * 32'(col) + 32'(i);
        return a[aw-1:0];
    endfunction

    // Activation vector address: abase + n, wrapping modulo 2^aw.
    function automatic logic [aw-1:0] a_addr(input logic [cw-1:0] n);
        logic [31:0] a;
        a = 32'(abase) + 32'(n);
        return a[aw-1:0];
    endfunction

    // Psum row address: k*len_nij + m, wrapping modulo 2^aw.
    function automatic logic [aw-1:0] p_addr(input logic [3:0] k, input logic [cw-1:0] m);
        logic [31:0] a;
        a = 32'(k) * 32'(len_nij) + 32'(m);
        return a[aw-1:0];
    endfunction

    assign l0_space = ~l0_o_full & l0_o_ready;

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        state_d     = state_q;
        kij_d       = kij_q;
        cnt_d       = cnt_q;
        issue_d     = issue_q;
        l0w_d       = l0w_q;
        ordc_d      = ordc_q;
        pwc_d       = pwc_q;
        xmem_cen_d  = 1'b1;
        xmem_addr_d = xmem_addr_q;
        l0_wr_d     = 1'b0;
        l0_rd_d     = 1'b0;
        load_d      = 1'b0;
        execute_d   = 1'b0;
        ofifo_rd_d  = 1'b0;
        pmem_wen_d  = 1'b1;
        pmem_addr_d = pmem_addr_q;
        done_d      = 1'b0;
        fill_len    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_KL0;
                    issue_d = '0;
                    l0w_d   = '0;
                end
            end
            S_KL0: begin
                // Leave once the final l0_wr of the slice is on the wire.
                if (l0w_q == cw'(col)) begin
                    state_d = S_KPE;
                    l0_rd_d = 1'b1;
                    load_d  = 1'b1;
                    cnt_d   = cw'(1);
                end
            end
            S_KPE: begin
                if (cnt_q == cw'(col)) begin
                    state_d = S_KFLUSH;
                    cnt_d   = cw'(1);
                end else begin
                    l0_rd_d = 1'b1;
                    load_d  = 1'b1;
                    cnt_d   = cnt_q + cw'(1);
                end
            end
            S_KFLUSH: begin
                // Quiet cycles while the kernel ripples across the array.
                if (cnt_q == cw'(row + col)) begin
                    state_d = S_AL0;
                    cnt_d   = '0;
                    issue_d = '0;
                    l0w_d   = '0;
                end else begin
                    cnt_d = cnt_q + cw'(1);
                end
            end
            S_AL0: begin
                if (l0w_q == cw'(len_nij)) begin
                    state_d   = S_EXEC;
                    l0_rd_d   = 1'b1;
                    execute_d = 1'b1;
                    cnt_d     = cw'(1);
                end
            end
            S_EXEC: begin
                if (cnt_q == cw'(len_nij)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    ordc_d  = '0;
                    pwc_d   = '0;
                end else begin
                    l0_rd_d   = 1'b1;
                    execute_d = 1'b1;
                    cnt_d     = cnt_q + cw'(1);
                end
            end
            S_DRAIN: begin
                if (pwc_q == cw'(len_nij)) begin
                    state_d = S_NEXT;
                end else if ((ordc_q != cw'(len_nij)) && ofifo_o_valid) begin
                    ofifo_rd_d = 1'b1;
                    ordc_d     = ordc_q + cw'(1);
                end
            end
            S_NEXT: begin
                if (kij_q == 4'(len_kij - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_KL0;
                    kij_d   = kij_q + 4'd1;
                    issue_d = '0;
                    l0w_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                kij_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // L0 fill: launch the next xmem read whenever the next cycle is a
        // fill cycle, reads remain and L0 has space; otherwise hold the address.
        if ((state_d == S_KL0) || (state_d == S_AL0)) begin
            fill_len = (state_d == S_KL0) ? cw'(col) : cw'(len_nij);
            if (l0_space && (issue_d != fill_len)) begin
                xmem_cen_d  = 1'b0;
                xmem_addr_d = (state_d == S_KL0) ? k_addr(kij_d, issue_d) : a_addr(issue_d);
                issue_d     = issue_d + cw'(1);
            end
        end

        // SRAM data returns one cycle after the read: write it into L0.
        if (!xmem_cen_q) begin
            l0_wr_d = 1'b1;
            l0w_d   = l0w_d + cw'(1);
        end

        // A popped OFIFO row is written to psum SRAM on the following cycle.
        if (ofifo_rd_q) begin
            pmem_wen_d  = 1'b0;
            pmem_addr_d = p_addr(kij_q, pwc_q);
            pwc_d       = pwc_d + cw'(1);
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, counters and registered outputs; reset aborts any run in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            kij_q       <= 4'd0;
            cnt_q       <= '0;
            issue_q     <= '0;
            l0w_q       <= '0;
            ordc_q      <= '0;
            pwc_q       <= '0;
            xmem_cen_q  <= 1'b1;
            xmem_addr_q <= '0;
            l0_wr_q     <= 1'b0;
            l0_rd_q     <= 1'b0;
            load_q      <= 1'b0;
            execute_q   <= 1'b0;
            ofifo_rd_q  <= 1'b0;
            pmem_wen_q  <= 1'b1;
            pmem_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            kij_q       <= kij_d;
            cnt_q       <= cnt_d;
            issue_q     <= issue_d;
            l0w_q       <= l0w_d;
            ordc_q      <= ordc_d;
            pwc_q       <= pwc_d;
            xmem_cen_q  <= xmem_cen_d;
            xmem_addr_q <= xmem_addr_d;
            l0_wr_q     <= l0_wr_d;
            l0_rd_q     <= l0_rd_d;
            load_q      <= load_d;
            execute_q   <= execute_d;
            ofifo_rd_q  <= ofifo_rd_d;
            pmem_wen_q  <= pmem_wen_d;
            pmem_addr_q <= pmem_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign xmem_cen  = xmem_cen_q;
    assign xmem_addr = xmem_addr_q;
    assign l0_wr     = l0_wr_q;
    assign l0_rd     = l0_rd_q;
    assign load      = load_q;
    assign execute   = execute_q;
    assign ofifo_rd  = ofifo_rd_q;
    assign pmem_wen  = pmem_wen_q;
    assign pmem_addr = pmem_addr_q;
    assign kij       = kij_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: drives full convolution runs through corelet_ctrl with an
// L0 that can stall and an OFIFO whose valid toggles, and scores the xmem
// read and psum write address streams against expected queues.
`timescale 1ns/1ps
module tb_corelet_ctrl;

    localparam int ROW     = 8;
    localparam int COL     = 8;
    localparam int LEN_KIJ = 9;
    localparam int LEN_NIJ = 36;
    localparam int AW      = 11;
    localparam int KBASE   = 0;
    localparam int ABASE   = 'h400;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done;
    logic          l0_o_full, l0_o_ready, ofifo_o_valid;
    logic          xmem_cen;
    logic [AW-1:0] xmem_addr;
    logic          l0_wr, l0_rd, load, execute, ofifo_rd, pmem_wen;
    logic [AW-1:0] pmem_addr;
    logic [3:0]    kij;

    always #5 clk = ~clk;
    assign l0_o_ready = ~l0_o_full;

    corelet_ctrl #(
        .row(ROW), .col(COL), .len_kij(LEN_KIJ), .len_nij(LEN_NIJ),
        .aw(AW), .kbase(KBASE), .abase(ABASE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .l0_o_full(l0_o_full), .l0_o_ready(l0_o_ready), .ofifo_o_valid(ofifo_o_valid),
        .xmem_cen(xmem_cen), .xmem_addr(xmem_addr), .l0_wr(l0_wr), .l0_rd(l0_rd),
        .load(load), .execute(execute), .ofifo_rd(ofifo_rd), .pmem_wen(pmem_wen),
        .pmem_addr(pmem_addr), .kij(kij)
    );

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [AW-1:0] exp_x[$];
    logic [AW-1:0] exp_p[$];

    logic mon_en = 1'b0;
    logic rand_valid = 1'b0;
    logic stall_arm = 1'b0;
    int   stall_left = 0;

    logic full_seen = 1'b0, valid_seen = 1'b0, cen_seen = 1'b1, ofrd_seen = 1'b0;
    logic load_prev, exec_prev, done_prev, gap_armed;
    int   load_run, exec_run, gap_cnt, seg_wr, pass_idx, wr_total, done_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic mon_clear();
        load_prev = 1'b0; exec_prev = 1'b0; done_prev = 1'b0; gap_armed = 1'b0;
        load_run = 0; exec_run = 0; gap_cnt = 0; seg_wr = 0;
        pass_idx = 0; wr_total = 0; done_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      32'(busy), 0);
        check({tag, "_done"},      32'(done), 0);
        check({tag, "_xmem_cen"},  32'(xmem_cen), 1);
        check({tag, "_pmem_wen"},  32'(pmem_wen), 1);
        check({tag, "_l0_wr"},     32'(l0_wr), 0);
        check({tag, "_l0_rd"},     32'(l0_rd), 0);
        check({tag, "_load"},      32'(load), 0);
        check({tag, "_execute"},   32'(execute), 0);
        check({tag, "_ofifo_rd"},  32'(ofifo_rd), 0);
        check({tag, "_xmem_addr"}, 32'(xmem_addr), 0);
        check({tag, "_pmem_addr"}, 32'(pmem_addr), 0);
        check({tag, "_kij"},       32'(kij), 0);
    endtask

    // Values the DUT saw on the rising edge (read before its flops update).
    initial forever begin
        @(posedge clk);
        full_seen  = l0_o_full;
        valid_seen = ofifo_o_valid;
        cen_seen   = xmem_cen;
        ofrd_seen  = ofifo_rd;
    end

    // ---------------- input drivers: L0 stall and OFIFO valid ----------------
    initial forever begin
        @(negedge clk);
        ofifo_o_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        if (stall_arm && !xmem_cen && (32'(xmem_addr) == ABASE + 3)) begin
            stall_arm  = 1'b0;
            stall_left = 5;
        end
        if (stall_left > 0) begin
            l0_o_full  = 1'b1;
            stall_left = stall_left - 1;
        end else begin
            l0_o_full = 1'b0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            check("load_exec_excl", 32'(load & execute), 0);
            check("wr_rd_excl", 32'(l0_wr & l0_rd), 0);
            check("l0_rd_match", 32'(l0_rd), 32'(load | execute));
            if (l0_wr || !cen_seen) check("l0_wr_lag", 32'(l0_wr), 32'(!cen_seen));
            if (full_seen) check("stall_cen", 32'(xmem_cen), 1);
            if (l0_wr) seg_wr++;

            // load phase boundaries and flush gap
            if (load) load_run++;
            if (load && !load_prev) begin
                load_run = 1;
                check("kpe_kij", 32'(kij), 32'(pass_idx));
                check("kpe_rows_written", 32'(wr_total), 32'(pass_idx * LEN_NIJ));
                check("kl0_wr_count", 32'(seg_wr), COL);
                seg_wr = 0;
                pass_idx++;
            end
            if (!load && load_prev) begin
                check("load_run", 32'(load_run), COL);
                gap_armed = 1'b1;
                gap_cnt   = 0;
            end
            if (gap_armed) begin
                if (!xmem_cen) begin
                    check("flush_gap", 32'(gap_cnt), ROW + COL);
                    gap_armed = 1'b0;
                end else begin
                    gap_cnt++;
                end
            end

            // execute phase boundaries
            if (execute) exec_run++;
            if (execute && !exec_prev) begin
                exec_run = 1;
                check("al0_wr_count", 32'(seg_wr), LEN_NIJ);
                seg_wr = 0;
            end
            if (!execute && exec_prev) check("exec_run", 32'(exec_run), LEN_NIJ);

            // xmem read address stream
            if (!xmem_cen) begin
                if (exp_x.size() == 0) check("xaddr_queue_nonempty", 32'(exp_x.size()), 1);
                else check("xaddr", 32'(xmem_addr), 32'(exp_x.pop_front()));
            end

            // OFIFO pop / psum write stream
            if (ofifo_rd) check("ofifo_rd_when_valid", 32'(valid_seen), 1);
            if (!pmem_wen || ofrd_seen) check("wen_lag", 32'(!pmem_wen), 32'(ofrd_seen));
            if (!pmem_wen) begin
                wr_total++;
                if (exp_p.size() == 0) check("paddr_queue_nonempty", 32'(exp_p.size()), 1);
                else check("pmem_addr", 32'(pmem_addr), 32'(exp_p.pop_front()));
            end

            if (done) begin
                done_cnt++;
                check("done_width", 32'(done_prev), 0);
                check("done_rows_total", 32'(wr_total), LEN_KIJ * LEN_NIJ);
                check("done_xq_empty", 32'(exp_x.size()), 0);
                check("done_pq_empty", 32'(exp_p.size()), 0);
                check("done_busy", 32'(busy), 1);
            end

            load_prev = load;
            exec_prev = execute;
            done_prev = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_conv();
        exp_x.delete();
        exp_p.delete();
        for (int k = 0; k < LEN_KIJ; k++) begin
            for (int i = 0; i < COL; i++) exp_x.push_back(AW'(KBASE + k * COL + i));
            for (int n = 0; n < LEN_NIJ; n++) exp_x.push_back(AW'(ABASE + n));
            for (int m = 0; m < LEN_NIJ; m++) exp_p.push_back(AW'(k * LEN_NIJ + m));
        end
        mon_clear();
        mon_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One complete run; extra_start_at >= 0 pulses start mid-run (must be ignored).
    task automatic run_conv(input int extra_start_at);
        logic seen;
        seen = 1'b0;
        start_conv();
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            start = (c == extra_start_at);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("run_done_seen", 32'(seen), 1);
        repeat (3) @(negedge clk);
        check("after_busy", 32'(busy), 0);
        check("after_done", 32'(done), 0);
        check("after_done_count", 32'(done_cnt), 1);
        check("after_kij", 32'(kij), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic seen;
        reset = 1'b0;
        start = 1'b0;
        l0_o_full = 1'b0;
        ofifo_o_valid = 1'b0;
        mon_clear();
        #23;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("idle_cen", 32'(xmem_cen), 1);

        // Run 1: L0 stall during pass 0 AL0, random OFIFO valid.
        stall_arm  = 1'b1;
        rand_valid = 1'b1;
        run_conv(-1);
        check("stall_happened", 32'(stall_arm), 0);

        // Run 2: abort with reset during pass 3 EXEC.
        start_conv();
        seen = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if ((kij == 4'd3) && execute) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_reached_exec3", 32'(seen), 1);
        repeat (4) @(negedge clk);
        check("abort_pre_execute", 32'(execute), 1);
        mon_en = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (3) @(negedge clk);
        check_reset_outputs("abort_hold");
        check("abort_no_done", 32'(done_cnt), 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_idle_busy", 32'(busy), 0);
        check("abort_idle_done", 32'(done), 0);
        check("abort_idle_cen", 32'(xmem_cen), 1);

        // Run 3: fresh start from kij 0, no stalls, stray start mid-run.
        rand_valid = 1'b0;
        run_conv(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
